// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalise/round path.
// Holds the default float format, derived widths, field offsets and the
// constant bit patterns for infinity and zero.
package fp_pkg;

    localparam int DEF_EXPONENT = 8;
    localparam int DEF_MANTISSA = 23;

    localparam int EXP_BIAS = (1 << (DEF_EXPONENT - 1)) - 1;

    // Adder magnitude: 2 extra MSBs, hidden bit, fraction, 2 guard LSBs.
    localparam int SUM_W   = DEF_MANTISSA + 5;
    // Internal exponent: signed, with headroom for overflow and underflow.
    localparam int EXPI_W  = DEF_EXPONENT + 2;
    localparam int FLOAT_W = DEF_EXPONENT + DEF_MANTISSA + 1;

    // Packed-float field offsets.
    localparam int FRAC_LSB = 0;
    localparam int EXP_LSB  = DEF_MANTISSA;
    localparam int SIGN_BIT = DEF_EXPONENT + DEF_MANTISSA;

    function automatic logic [FLOAT_W-1:0] inf_pattern(input logic sign);
        logic [FLOAT_W-1:0] pat;
        pat                           = '0;
        pat[SIGN_BIT]                 = sign;
        pat[EXP_LSB +: DEF_EXPONENT]  = '1;
        return pat;
    endfunction

    function automatic logic [FLOAT_W-1:0] zero_pattern(input logic sign);
        logic [FLOAT_W-1:0] pat;
        pat           = '0;
        pat[SIGN_BIT] = sign;
        return pat;
    endfunction

endpackage

// File: rtl/fp_norm_round_if.sv
// Handshake bundle between the mantissa adder, the normaliser/rounder and
// the accumulator stage.
//   in_valid/in_ready          : input beat handshake
//   sum_unsigned/sum_sign      : sign-magnitude sum from the adder
//   exp_max                    : common aligned exponent
//   out_valid/out_ready        : output beat handshake
//   result/ovf/unf             : packed float and saturation flags
// master = upstream+downstream driver side, slave = the rounder.
interface fp_norm_round_if #(
    parameter int EXPONENT = 8,
    parameter int MANTISSA = 23
);
    logic                         in_valid;
    logic                         in_ready;
    logic [MANTISSA+4:0]          sum_unsigned;
    logic                         sum_sign;
    logic [EXPONENT-1:0]          exp_max;
    logic                         out_valid;
    logic                         out_ready;
    logic [EXPONENT+MANTISSA:0]   result;
    logic                         ovf;
    logic                         unf;

    modport master (
        output in_valid, sum_unsigned, sum_sign, exp_max, out_ready,
        input  in_ready, out_valid, result, ovf, unf
    );

    modport slave (
        input  in_valid, sum_unsigned, sum_sign, exp_max, out_ready,
        output in_ready, out_valid, result, ovf, unf
    );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//   data     : operand
//   count    : number of zeros above the most significant one (WIDTH if zero)
//   all_zero : operand is zero
module fp_lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Ascending scan: the last hit is the most significant one.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign all_zero = ~|data;

endmodule

// File: rtl/fp_norm_round.sv
// Three-stage normaliser/rounder behind the three-input mantissa adder.
// S1 captures the sum and finds its leading one, S2 normalises and forms
// the exponent, S3 rounds to nearest-even and packs the result.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp_norm_round_if slave (input beat in, packed float out)
// The float format defaults come from fp_pkg; the packed INF/ZERO patterns
// assume the instance uses that default format.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXPONENT = DEF_EXPONENT,
    parameter int MANTISSA = DEF_MANTISSA
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_norm_round_if.slave bus
);

    localparam int SW    = MANTISSA + 5;
    localparam int EW    = EXPONENT + 2;
    localparam int FW    = EXPONENT + MANTISSA + 1;
    localparam int LZC_W = $clog2(SW + 1);

    logic v1, v2, v3;
    logic adv1, adv2;

    logic [SW-1:0]       s1_sum;
    logic                s1_sign;
    logic [EXPONENT-1:0] s1_exp;
    logic [LZC_W-1:0]    s1_lzc;
    logic                s1_zero;
    logic [SW-2:0]       s1_shifted;
    logic signed [EW-1:0] s1_e;

    logic [MANTISSA-1:0] s2_frac;
    logic                s2_guard;
    logic                s2_sticky;
    logic                s2_zero;
    logic                s2_sign;
    logic signed [EW-1:0] s2_e;

    logic                 round_up;
    logic [MANTISSA:0]    frac_sum;
    logic signed [EW-1:0] e_r;
    logic [FW-1:0]        next_result;
    logic                 next_ovf;
    logic                 next_unf;

    logic [FW-1:0] result_q;
    logic          ovf_q;
    logic          unf_q;

    // A stage may load when it is empty or its successor is draining,
    // so bubbles collapse and in_ready follows out_ready combinationally.
    assign adv2         = !v3 || bus.out_ready;
    assign adv1         = !v2 || adv2;
    assign bus.in_ready = !v1 || adv1;

    assign bus.out_valid = v3;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

    fp_lzc #(.WIDTH(SW), .CNT_W(LZC_W)) u_lzc (
        .data     (s1_sum),
        .count    (s1_lzc),
        .all_zero (s1_zero)
    );

    // After the shift the leading one sits in the MSB, which is implied,
    // so only the bits below it are kept.
    assign s1_shifted = (SW-1)'(s1_sum << s1_lzc);

    // e = exp_max + p - (MANTISSA+2), with p = (MANTISSA+4) - lzc.
    assign s1_e = $signed(EW'(s1_exp)) + $signed(EW'(MANTISSA + 4))
                - $signed(EW'(s1_lzc)) - $signed(EW'(MANTISSA + 2));

    // Round half to even; a carry out of the fraction bumps the exponent
    // and leaves the fraction at zero.
    always_comb begin
        round_up = s2_guard && (s2_sticky || s2_frac[0]);
        frac_sum = {1'b0, s2_frac} + {{MANTISSA{1'b0}}, round_up};
        e_r      = s2_e + $signed({{(EW-1){1'b0}}, frac_sum[MANTISSA]});
        next_ovf = 1'b0;
        next_unf = 1'b0;
        if (s2_zero) begin
            next_result = zero_pattern(1'b0);
        end else if (e_r >= $signed(EW'((1 << EXPONENT) - 1))) begin
            next_result = inf_pattern(s2_sign);
            next_ovf    = 1'b1;
        end else if (e_r <= $signed(EW'(0))) begin
            next_result = zero_pattern(s2_sign);
            next_unf    = 1'b1;
        end else begin
            next_result = {s2_sign, e_r[EXPONENT-1:0], frac_sum[MANTISSA-1:0]};
        end
    end

    // S1: capture the adder output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_sum  <= '0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
        end else if (bus.in_ready) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum  <= bus.sum_unsigned;
                s1_sign <= bus.sum_sign;
                s1_exp  <= bus.exp_max;
            end
        end
    end

    // S2: register the normalised fraction, guard/sticky and exponent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            s2_frac   <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_zero   <= 1'b0;
            s2_sign   <= 1'b0;
            s2_e      <= '0;
        end else if (adv1) begin
            v2 <= v1;
            if (v1) begin
                s2_frac   <= s1_shifted[MANTISSA+3:4];
                s2_guard  <= s1_shifted[3];
                s2_sticky <= |s1_shifted[2:0];
                s2_zero   <= s1_zero;
                s2_sign   <= s1_sign;
                s2_e      <= s1_e;
            end
        end
    end

    // S3: register the packed result; it holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (adv2) begin
            v3 <= v2;
            if (v2) begin
                result_q <= next_result;
                ovf_q    <= next_ovf;
                unf_q    <= next_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vectors, back-pressure,
// reset mid-flight and a randomized stream against a reference model.
module tb_fp_norm_round;

    localparam int E  = 8;
    localparam int M  = 23;
    localparam int SW = M + 5;
    localparam int FW = E + M + 1;
    localparam int RAND_BEATS = 10000;

    typedef struct {
        logic [SW-1:0] sum;
        logic          sign;
        logic [E-1:0]  exp;
        logic [FW-1:0] res;
        logic          ovf;
        logic          unf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [FW+1:0] expq[$];

    always #5 clk = ~clk;

    fp_norm_round_if #(.EXPONENT(E), .MANTISSA(M)) bus ();

    fp_norm_round #(.EXPONENT(E), .MANTISSA(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [SW-1:0] s, input logic sg, input logic [E-1:0] ex);
        bus.in_valid     = v;
        bus.sum_unsigned = s;
        bus.sum_sign     = sg;
        bus.exp_max      = ex;
    endtask

    // Reference: find the leading one, keep a 24-bit significand, round the
    // discarded remainder half-to-even, then classify the exponent.
    function automatic logic [FW+1:0] refModel(input logic [SW-1:0] sum, input logic sign, input logic [E-1:0] ex);
        logic [63:0] s, sig, rem, half;
        int p, e, sh;
        if (sum == '0) return '0;
        s = 64'(sum);
        p = 0;
        for (int i = 0; i < SW; i++) if (sum[i]) p = i;
        e  = int'(ex) + p - (M + 2);
        sh = p - M;
        if (sh > 0) begin
            sig  = s >> sh;
            rem  = s & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
        end else begin
            sig = s << (-sh);
        end
        if (sig == (64'd1 << (M + 1))) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= (1 << E) - 1) return {1'b1, 1'b0, sign, {E{1'b1}}, {M{1'b0}}};
        if (e <= 0)            return {1'b0, 1'b1, sign, {(E+M){1'b0}}};
        return {2'b00, sign, e[E-1:0], sig[M-1:0]};
    endfunction

    function automatic logic [SW-1:0] randSum();
        logic [SW-1:0] r;
        r = SW'($urandom);
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return r >> $urandom_range(0, SW - 1);
            2:       return {3'b001, {(SW-8){1'b1}}, r[4:0]};
            default: return ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [FW+1:0] dutOut();
        return {bus.ovf, bus.unf, bus.result};
    endfunction

    // One beat through an empty pipe, expecting the result on the third edge.
    task automatic runSingle(input string tag, input vec_t v);
        int lat;
        @(negedge clk);
        applyStimulus(1'b1, v.sum, v.sign, v.exp);
        bus.out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'b0;
        end while (!bus.out_valid && lat < 10);
        if (!bus.out_valid) begin
            checkOutput({tag, "_timeout"}, 64'(bus.out_valid), 64'd1);
        end else begin
            checkOutput({tag, "_latency"}, 64'(lat), 64'd3);
            checkOutput({tag, "_result"},  64'(bus.result), 64'(v.res));
            checkOutput({tag, "_ovf"},     64'(bus.ovf), 64'(v.ovf));
            checkOutput({tag, "_unf"},     64'(bus.unf), 64'(v.unf));
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        int   sent, got, cyc;
        logic hold;
        logic [FW+1:0] want;
        logic stale;

        vecs.push_back('{28'h2000000, 1'b0, 8'd127, 32'h3F800000, 1'b0, 1'b0});
        vecs.push_back('{28'h4000000, 1'b0, 8'd127, 32'h40000000, 1'b0, 1'b0});
        vecs.push_back('{28'h8000000, 1'b1, 8'd127, 32'hC0800000, 1'b0, 1'b0});
        vecs.push_back('{28'h2000002, 1'b0, 8'd127, 32'h3F800000, 1'b0, 1'b0});
        vecs.push_back('{28'h2000006, 1'b0, 8'd127, 32'h3F800002, 1'b0, 1'b0});
        vecs.push_back('{28'h2000003, 1'b0, 8'd127, 32'h3F800001, 1'b0, 1'b0});
        vecs.push_back('{28'h3FFFFFE, 1'b0, 8'd127, 32'h40000000, 1'b0, 1'b0});
        vecs.push_back('{28'h0000004, 1'b0, 8'd127, 32'h34000000, 1'b0, 1'b0});
        vecs.push_back('{28'h0000000, 1'b1, 8'd127, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{28'h8000000, 1'b0, 8'd253, 32'h7F800000, 1'b1, 1'b0});
        vecs.push_back('{28'h0000001, 1'b0, 8'd20,  32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{28'h0000001, 1'b1, 8'd20,  32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{28'h2000000, 1'b0, 8'd254, 32'h7F000000, 1'b0, 1'b0});
        vecs.push_back('{28'h3FFFFFE, 1'b1, 8'd254, 32'hFF800000, 1'b1, 1'b0});
        vecs.push_back('{28'h2000000, 1'b0, 8'd1,   32'h00800000, 1'b0, 1'b0});
        vecs.push_back('{28'h1000000, 1'b0, 8'd1,   32'h00000000, 1'b0, 1'b1});

        applyStimulus(1'b0, '0, 1'b0, '0);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_result",    64'(bus.result),    64'd0);
        checkOutput("reset_ovf",       64'(bus.ovf),       64'd0);
        checkOutput("reset_unf",       64'(bus.unf),       64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] directed vectors");
        foreach (vecs[i]) runSingle($sformatf("vec%0d", i), vecs[i]);

        // Six beats with downstream stalled in cycles 4..8.
        $display("[TB] back-pressure sequence");
        expq.delete();
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            if (sent < 6)
                applyStimulus(1'b1, 28'h2000000 + SW'(sent) * 28'h0123457, sent[0], 8'(100 + sent));
            else
                bus.in_valid = 1'b0;
            bus.out_ready = !(c >= 4 && c <= 8);
            #1;
            if (c == 6) checkOutput("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            if (c >= 4 && c <= 8) begin
                checkOutput("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                if (expq.size() == 0) checkOutput("bp_hold_empty", 64'd0, 64'd1);
                else checkOutput("bp_hold_result", 64'(dutOut()), 64'(expq[0]));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("bp_extra_beat", 64'd1, 64'd0);
                end else begin
                    want = expq.pop_front();
                    checkOutput("bp_beat", 64'(dutOut()), 64'(want));
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(refModel(bus.sum_unsigned, bus.sum_sign, bus.exp_max));
                sent++;
            end
        end
        checkOutput("bp_count", 64'(got), 64'd6);

        // Reset with two beats in flight, the oldest already at the output.
        $display("[TB] reset mid-flight");
        @(negedge clk);
        applyStimulus(1'b1, 28'h2000000, 1'b0, 8'd127);
        bus.out_ready = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 28'h4000000, 1'b1, 8'd130);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_result",    64'(bus.result),    64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        stale = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        checkOutput("rst_no_stale", 64'(stale), 64'd0);
        runSingle("rst_after", vecs[2]);

        $display("[TB] randomized stream");
        expq.delete();
        sent = 0;
        got  = 0;
        cyc  = 0;
        hold = 1'b0;
        while ((sent < RAND_BEATS || expq.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                if (sent < RAND_BEATS && $urandom_range(0, 3) != 0)
                    applyStimulus(1'b1, randSum(), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                else
                    bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("rand_extra_beat", 64'd1, 64'd0);
                end else begin
                    want = expq.pop_front();
                    checkOutput($sformatf("rand_beat%0d", got), 64'(dutOut()), 64'(want));
                end
                got++;
            end
            hold = bus.in_valid && !bus.in_ready;
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(refModel(bus.sum_unsigned, bus.sum_sign, bus.exp_max));
                sent++;
            end
        end
        if (cyc >= 60000) checkOutput("rand_timeout", 64'(got), 64'(RAND_BEATS));
        checkOutput("rand_count", 64'(got), 64'(RAND_BEATS));

        bus.in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
